// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default field widths, the Tnew value shown by
// an empty stage, the occupancy state encoding and per-entry register ops.
package pipe_stage_reg_pkg;

    localparam int DEF_PAYLOAD_W = 128;
    localparam int DEF_A3_W      = 5;
    localparam int DEF_TNEW_W    = 2;
    localparam logic [DEF_TNEW_W-1:0] DEF_TNEW_RST = '1;

    // Encoding equals occupancy so the count falls straight out of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // What one storage entry does at the next edge.
    typedef enum logic [1:0] {
        ENT_KEEP  = 2'd0,   // unused slot: leave untouched
        ENT_LOAD  = 2'd1,   // capture new fields, Tnew saturating-decremented
        ENT_HOLD  = 2'd2,   // keep fields, Tnew saturating-decremented
        ENT_CLEAR = 2'd3    // return to the empty-slot values
    } entry_op_t;

    function automatic logic [1:0] state_count(input state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying one pipeline entry.
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int A3_W      = DEF_A3_W,
    parameter int TNEW_W    = DEF_TNEW_W
) ();

    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;
    logic                 regwe;
    logic [A3_W-1:0]      a3;
    logic [TNEW_W-1:0]    tnew;

    modport master (output valid, payload, regwe, a3, tnew, input ready);
    modport slave  (input valid, payload, regwe, a3, tnew, output ready);

endinterface

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload, write enable, destination and a Tnew counter
// that saturates at zero. CLR_TNEW is the Tnew value of an empty slot.
module pipe_entry_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int A3_W      = DEF_A3_W,
    parameter int TNEW_W    = DEF_TNEW_W,
    parameter logic [TNEW_W-1:0] CLR_TNEW = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  entry_op_t            op,
    input  logic [PAYLOAD_W-1:0] ld_payload,
    input  logic                 ld_regwe,
    input  logic [A3_W-1:0]      ld_a3,
    input  logic [TNEW_W-1:0]    ld_tnew,
    output logic [PAYLOAD_W-1:0] payload,
    output logic                 regwe,
    output logic [A3_W-1:0]      a3,
    output logic [TNEW_W-1:0]    tnew
);

    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 regwe_q, regwe_d;
    logic [A3_W-1:0]      a3_q, a3_d;
    logic [TNEW_W-1:0]    tnew_q, tnew_d;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Next-value selection for the requested entry operation.
    always_comb begin
        payload_d = payload_q;
        regwe_d   = regwe_q;
        a3_d      = a3_q;
        tnew_d    = tnew_q;
        case (op)
            ENT_LOAD: begin
                payload_d = ld_payload;
                regwe_d   = ld_regwe;
                a3_d      = ld_a3;
                tnew_d    = sat_dec(ld_tnew);
            end
            ENT_HOLD: begin
                tnew_d = sat_dec(tnew_q);
            end
            ENT_CLEAR: begin
                payload_d = '0;
                regwe_d   = 1'b0;
                a3_d      = '0;
                tnew_d    = CLR_TNEW;
            end
            default: ;
        endcase
    end

    // Entry registers with synchronous reset to the empty-slot values.
    always_ff @(posedge clk) begin
        if (reset) begin
            payload_q <= '0;
            regwe_q   <= 1'b0;
            a3_q      <= '0;
            tnew_q    <= CLR_TNEW;
        end else begin
            payload_q <= payload_d;
            regwe_q   <= regwe_d;
            a3_q      <= a3_d;
            tnew_q    <= tnew_d;
        end
    end

    assign payload = payload_q;
    assign regwe   = regwe_q;
    assign a3      = a3_q;
    assign tnew    = tnew_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register (HEAD drives the outputs, SKID absorbs
// one extra entry) so in_ready depends only on registered state and flush.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int A3_W      = DEF_A3_W,
    parameter int TNEW_W    = DEF_TNEW_W,
    parameter logic [TNEW_W-1:0] TNEW_RST = {TNEW_W{DEF_TNEW_RST[0]}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   in_if,
    pipe_stage_reg_if.master  out_if,
    output logic [1:0]        out_count
);

    localparam int HEAD = 0;
    localparam int SKID = 1;

    state_t               state_q, state_d;
    entry_op_t            ent_op         [2];
    logic [PAYLOAD_W-1:0] ent_ld_payload [2];
    logic                 ent_ld_regwe   [2];
    logic [A3_W-1:0]      ent_ld_a3      [2];
    logic [TNEW_W-1:0]    ent_ld_tnew    [2];
    logic [PAYLOAD_W-1:0] ent_payload    [2];
    logic                 ent_regwe      [2];
    logic [A3_W-1:0]      ent_a3         [2];
    logic [TNEW_W-1:0]    ent_tnew       [2];
    logic                 head_from_skid;
    logic                 accept;
    logic                 pop;

    assign in_if.ready  = (state_q != ST_FULL) && !flush;
    // Reset suppresses the downstream handshake in the cycle it is applied.
    assign out_if.valid = (state_q != ST_EMPTY) && !reset;
    assign accept       = in_if.valid && in_if.ready;
    assign pop          = out_if.valid && out_if.ready;

    // Occupancy state machine choosing an operation for each entry.
    always_comb begin
        state_d        = state_q;
        ent_op[HEAD]   = ENT_KEEP;
        ent_op[SKID]   = ENT_KEEP;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d      = ST_EMPTY;
            ent_op[HEAD] = ENT_CLEAR;
            ent_op[SKID] = ENT_CLEAR;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        ent_op[HEAD] = ENT_LOAD;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        ent_op[HEAD] = ENT_LOAD;
                    end else if (accept) begin
                        state_d      = ST_FULL;
                        ent_op[HEAD] = ENT_HOLD;
                        ent_op[SKID] = ENT_LOAD;
                    end else if (pop) begin
                        state_d      = ST_EMPTY;
                        ent_op[HEAD] = ENT_CLEAR;
                    end else begin
                        ent_op[HEAD] = ENT_HOLD;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d        = ST_ONE;
                        ent_op[HEAD]   = ENT_LOAD;
                        ent_op[SKID]   = ENT_CLEAR;
                        head_from_skid = 1'b1;
                    end else begin
                        ent_op[HEAD] = ENT_HOLD;
                        ent_op[SKID] = ENT_HOLD;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    ent_op[HEAD] = ENT_CLEAR;
                    ent_op[SKID] = ENT_CLEAR;
                end
            endcase
        end
    end

    // Load sources: HEAD takes SKID when draining, otherwise the input port.
    always_comb begin
        ent_ld_payload[HEAD] = head_from_skid ? ent_payload[SKID] : in_if.payload;
        ent_ld_regwe[HEAD]   = head_from_skid ? ent_regwe[SKID]   : in_if.regwe;
        ent_ld_a3[HEAD]      = head_from_skid ? ent_a3[SKID]      : in_if.a3;
        ent_ld_tnew[HEAD]    = head_from_skid ? ent_tnew[SKID]    : in_if.tnew;
        ent_ld_payload[SKID] = in_if.payload;
        ent_ld_regwe[SKID]   = in_if.regwe;
        ent_ld_a3[SKID]      = in_if.a3;
        ent_ld_tnew[SKID]    = in_if.tnew;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            pipe_entry_reg #(
                .PAYLOAD_W (PAYLOAD_W),
                .A3_W      (A3_W),
                .TNEW_W    (TNEW_W),
                .CLR_TNEW  ((gi == HEAD) ? TNEW_RST : '0)
            ) u_entry (
                .clk        (clk),
                .reset      (reset),
                .op         (ent_op[gi]),
                .ld_payload (ent_ld_payload[gi]),
                .ld_regwe   (ent_ld_regwe[gi]),
                .ld_a3      (ent_ld_a3[gi]),
                .ld_tnew    (ent_ld_tnew[gi]),
                .payload    (ent_payload[gi]),
                .regwe      (ent_regwe[gi]),
                .a3         (ent_a3[gi]),
                .tnew       (ent_tnew[gi])
            );
        end
    endgenerate

    // HEAD is cleared whenever it empties, so its registers already hold the
    // idle output values.
    assign out_if.payload = ent_payload[HEAD];
    assign out_if.regwe   = ent_regwe[HEAD];
    assign out_if.a3      = ent_a3[HEAD];
    assign out_if.tnew    = ent_tnew[HEAD];
    assign out_count      = state_count(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random test of pipe_stage_reg against a queue scoreboard.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int PW = DEF_PAYLOAD_W;
    localparam int AW = DEF_A3_W;
    localparam int TW = DEF_TNEW_W;
    localparam logic [TW-1:0] T_RST = DEF_TNEW_RST;

    typedef struct packed {
        logic [PW-1:0] payload;
        logic          regwe;
        logic [AW-1:0] a3;
        logic [TW-1:0] tnew;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] out_count;

    pipe_stage_reg_if in_if ();
    pipe_stage_reg_if out_if ();

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_if     (in_if),
        .out_if    (out_if),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    ent_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   verbose = 1'b1;

    function automatic logic [TW-1:0] sdec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // with the scoreboard head, then update the scoreboard at the rising edge.
    task automatic cycle(input logic v, input logic [PW-1:0] pl, input logic we,
                         input logic [AW-1:0] a3, input logic [TW-1:0] tn,
                         input logic ordy, input logic fl);
        bit   exp_valid, exp_ready, acc, pop;
        ent_t h, n;
        in_if.valid   = v;
        in_if.payload = pl;
        in_if.regwe   = we;
        in_if.a3      = a3;
        in_if.tnew    = tn;
        out_if.ready  = ordy;
        flush         = fl;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_ready = (exp_q.size() < 2) && !fl;
        if (exp_valid) begin
            h = exp_q[0];
        end else begin
            h.payload = '0;
            h.regwe   = 1'b0;
            h.a3      = '0;
            h.tnew    = T_RST;
        end
        check("out_valid",   PW'(out_if.valid),   PW'(exp_valid));
        check("out_count",   PW'(out_count),      PW'(exp_q.size()));
        check("in_ready",    PW'(in_if.ready),    PW'(exp_ready));
        check("out_payload", out_if.payload,      h.payload);
        check("out_regwe",   PW'(out_if.regwe),   PW'(h.regwe));
        check("out_a3",      PW'(out_if.a3),      PW'(h.a3));
        check("out_tnew",    PW'(out_if.tnew),    PW'(h.tnew));
        acc = v && exp_ready;
        pop = exp_valid && ordy;
        if (verbose && (acc || pop || fl))
            $display("t=%0t flush=%0b in:%0b pl=%0h a3=%0d tnew=%0d | out:%0b pl=%0h a3=%0d tnew=%0d",
                     $time, fl, acc, pl, a3, tn, pop, out_if.payload, out_if.a3, out_if.tnew);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            foreach (exp_q[i]) exp_q[i].tnew = sdec(exp_q[i].tnew);
            if (acc) begin
                n.payload = pl;
                n.regwe   = we;
                n.a3      = a3;
                n.tnew    = sdec(tn);
                exp_q.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 1'b0, '0, '0, ordy, 1'b0);
    endtask

    // Holds reset for n edges; no downstream handshake may be offered meanwhile.
    task automatic apply_reset(input int n, input logic ordy);
        reset        = 1'b1;
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = ordy;
        #1;
        check("rst_out_valid", PW'(out_if.valid), PW'(1'b0));
        repeat (n) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        in_if.valid   = 1'b0;
        in_if.payload = '0;
        in_if.regwe   = 1'b0;
        in_if.a3      = '0;
        in_if.tnew    = '0;
        out_if.ready  = 1'b0;
        @(negedge clk);
        apply_reset(2, 1'b0);
        idle(1'b0);

        // First entry appears one cycle after acceptance with Tnew-1.
        cycle(1'b1, PW'(128'h33), 1'b1, AW'(8), TW'(2), 1'b1, 1'b0);
        check("r33_valid", PW'(out_if.valid), PW'(1'b1));
        check("r33_a3",    PW'(out_if.a3),    PW'(8));
        check("r33_tnew",  PW'(out_if.tnew),  PW'(1));
        check("r33_count", PW'(out_count),    PW'(1));
        idle(1'b1);

        // Back-pressure: fill both entries and watch A's Tnew count down.
        cycle(1'b1, PW'(128'hA), 1'b1, AW'(3), TW'(3), 1'b0, 1'b0);
        check("r34_tnew0", PW'(out_if.tnew), PW'(2));
        cycle(1'b1, PW'(128'hB), 1'b0, AW'(4), TW'(3), 1'b0, 1'b0);
        check("r34_tnew1", PW'(out_if.tnew), PW'(1));
        check("r34_count", PW'(out_count),   PW'(2));
        check("r34_ready", PW'(in_if.ready), PW'(1'b0));
        idle(1'b0);
        check("r34_tnew2", PW'(out_if.tnew), PW'(0));
        idle(1'b0);
        check("r34_tnew3", PW'(out_if.tnew), PW'(0));
        idle(1'b1);
        check("r34_b_pl",   out_if.payload,   PW'(128'hB));
        check("r34_b_tnew", PW'(out_if.tnew), PW'(0));
        idle(1'b1);

        // Flush while full, with a simultaneous offer and pop.
        cycle(1'b1, PW'(128'hC), 1'b1, AW'(5), TW'(2), 1'b0, 1'b0);
        cycle(1'b1, PW'(128'hD), 1'b1, AW'(6), TW'(2), 1'b0, 1'b0);
        cycle(1'b1, PW'(128'hE), 1'b1, AW'(7), TW'(2), 1'b1, 1'b1);
        check("r35_valid", PW'(out_if.valid), PW'(1'b0));
        check("r35_count", PW'(out_count),    PW'(0));
        check("r35_regwe", PW'(out_if.regwe), PW'(1'b0));
        check("r35_tnew",  PW'(out_if.tnew),  PW'(T_RST));
        idle(1'b1);
        idle(1'b1);

        // Streaming at full rate.
        for (int i = 0; i < 100; i++)
            cycle(1'b1, PW'(1000 + i), 1'(i % 2), AW'(i), TW'(i % 4), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset while full with downstream ready.
        cycle(1'b1, PW'(128'hF1), 1'b1, AW'(9), TW'(3), 1'b0, 1'b0);
        cycle(1'b1, PW'(128'hF2), 1'b1, AW'(10), TW'(3), 1'b0, 1'b0);
        apply_reset(1, 1'b1);
        check("r37_count", PW'(out_count),      PW'(0));
        check("r37_pl",    out_if.payload,      PW'(0));
        check("r37_a3",    PW'(out_if.a3),      PW'(0));
        check("r37_tnew",  PW'(out_if.tnew),    PW'(T_RST));
        idle(1'b1);

        // Random handshakes and occasional flushes.
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                  TW'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 15) == 0));
        end
        $display("random phase done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 128, width of opaque stage payload (PC, instr, ALU/MDU results, misc control).
REQ-002 Parameter A3_W, default 5, destination-register address width.
REQ-003 Parameter TNEW_W, default 2, width of the Tnew (cycles-until-result) field.
REQ-004 Parameter TNEW_RST, default all-ones of TNEW_W, Tnew value presented when the stage holds no instruction.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream offers an entry.
REQ-009 in_ready  output  1  stage can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-010 in_payload  input  PAYLOAD_W  upstream payload.
REQ-011 in_regwe, in_a3, in_tnew  input  1/A3_W/TNEW_W  upstream write-enable, destination, Tnew.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_ready  input  1  downstream accepts head; transfer when out_valid && out_ready.
REQ-014 out_payload, out_regwe, out_a3, out_tnew  output  PAYLOAD_W/1/A3_W/TNEW_W  head-entry fields.
REQ-015 out_count  output  2  occupancy, 0..2.

Function
REQ-016 Storage SHALL be two entries: HEAD (drives outputs) and SKID; state machine EMPTY (count 0), ONE (HEAD valid), FULL (HEAD and SKID valid).
REQ-017 in_ready SHALL equal (state != FULL) && !flush, derived only from registered state and flush.
REQ-018 EMPTY: accept -> ONE, entry into HEAD; no accept -> stay EMPTY.
REQ-019 ONE: accept && pop -> stay ONE, new entry into HEAD; accept only -> FULL, new entry into SKID; pop only -> EMPTY; neither -> stay ONE.
REQ-020 FULL: pop -> ONE, SKID moves to HEAD; no pop -> stay FULL; no accept possible.
REQ-021 Entry order SHALL be strict FIFO; no entry lost or duplicated.
REQ-022 Tnew on capture SHALL be stored as in_tnew-1, saturating at 0.
REQ-023 Every cycle an entry stays held (HEAD not popped, or SKID not moved), its stored Tnew SHALL decrement by 1, saturating at 0; an entry moving SKID->HEAD also decrements by 1.
REQ-024 When out_valid=0: out_regwe=0, out_a3=0, out_tnew=TNEW_RST, out_payload=0.
REQ-025 flush SHALL empty both entries at the next edge (state EMPTY) and override any simultaneous accept or pop; the simultaneously offered input is not captured.
REQ-026 Latency: an entry accepted into EMPTY SHALL appear on outputs the following cycle; throughput one entry per cycle when out_ready is held high.
REQ-027 Output fields SHALL be driven directly from HEAD registers (no combinational path from in_* to out_*).

Reset
REQ-028 reset SHALL have priority over flush and all handshakes.
REQ-029 After reset: state EMPTY, out_count=0, out_valid=0, in_ready=1 in the first cycle after reset deasserts, out_regwe=0, out_a3=0, out_tnew=TNEW_RST, out_payload=0, SKID fields zero.
REQ-030 reset asserted mid-operation SHALL discard both entries with no downstream transfer in the reset cycle.

Structure
REQ-031 A shared pipeline package SHALL hold the default widths (PAYLOAD_W, A3_W, TNEW_W), TNEW_RST and the state encoding EMPTY/ONE/FULL.
REQ-032 One sub-module pipe_entry_reg (one entry's payload/regwe/a3/tnew with load, clear and saturating Tnew decrement) SHALL be instantiated twice.

Verification
REQ-033 Reset then in_valid=1, in_tnew=2, in_a3=8, out_ready=1 -> next cycle out_valid=1, out_a3=8, out_tnew=1, out_count=1.
REQ-034 out_ready=0, push A (tnew 3) then B (tnew 3) -> out_count=2, in_ready=0, out_tnew of A steps 2,1,0,0; raise out_ready -> A then B emitted in order, B shows tnew 0.
REQ-035 FULL, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_count=0, out_regwe=0, out_tnew=TNEW_RST, flushed input not seen.
REQ-036 Continuous in_valid=1, out_ready=1 for 100 entries with incrementing payload -> 100 outputs in order, one per cycle, out_count stays 1.
REQ-037 reset asserted while FULL with out_ready=1 -> no output handshake that cycle; after release all outputs at REQ-029 values.
REQ-038 Random in_valid/out_ready/flush for 10000 cycles against a queue model -> order, Tnew and out_count match every cycle.
